// File: rtl/mux16_pkg.sv
// Shared constants, state encoding and select-range helpers for the 16:1 mux
// serial sequencer.
package mux16_pkg;

    localparam int MUX_WIDTH = 16;
    localparam int MUX_SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_e;

    // Last select index of a word: 15 when stepping up, 0 when stepping down.
    function automatic logic [MUX_SEL_W-1:0] final_sel(input logic msb_first);
        return msb_first ? {MUX_SEL_W{1'b0}} : {MUX_SEL_W{1'b1}};
    endfunction

    function automatic logic [MUX_SEL_W-1:0] first_sel(input logic msb_first);
        return final_sel(!msb_first);
    endfunction

endpackage

// File: rtl/mux16_serial_sequencer_if.sv
// Handshake and mux-bus bundle between the serial sequencer and its surroundings
// (upstream word source, downstream bit sink, and the 16:1 mux).
interface mux16_serial_sequencer_if;
    import mux16_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [MUX_WIDTH-1:0] in_data;
    logic [MUX_WIDTH-1:0] mux_datain;
    logic [MUX_SEL_W-1:0] mux_sel;
    logic                 mux_y;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_bit;
    logic                 out_last;
    logic                 busy;

    modport master (
        input  in_valid, in_data, mux_y, out_ready,
        output in_ready, mux_datain, mux_sel, out_valid, out_bit, out_last, busy
    );

    modport slave (
        output in_valid, in_data, mux_y, out_ready,
        input  in_ready, mux_datain, mux_sel, out_valid, out_bit, out_last, busy
    );

endinterface

// File: rtl/mux16_sel_counter.sv
// Loadable up/down select counter with enable; tc flags the terminal index.
module mux16_sel_counter
    import mux16_pkg::*;
#(
    parameter int SEL_W = MUX_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             down,
    input  logic [SEL_W-1:0] term,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // Load wins over count so a word start or word end always lands on a known index.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = down ? (cnt_q - SEL_W'(1)) : (cnt_q + SEL_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == term);

endmodule

// File: rtl/mux16_serial_sequencer.sv
// Drives a 16:1 mux with a held word and a stepping select, returning y as a
// valid/ready/last serial stream (parallel-to-serial with the external mux).
//
// state | meaning
// IDLE  | in_ready=1, waiting for a word; mux_sel parked at 0
// SHIFT | out_valid=1, busy=1, one bit per accepted beat until out_last
module mux16_serial_sequencer
    import mux16_pkg::*;
#(
    parameter int WIDTH     = MUX_WIDTH,
    parameter int SEL_W     = MUX_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mux16_serial_sequencer_if.master  bus
);

    localparam logic [SEL_W-1:0] SEL_START = first_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_FINAL = final_sel(MSB_FIRST);

    seq_state_e       state_q,     state_d;
    logic [WIDTH-1:0] data_q,      data_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic             accept;
    logic             beat;
    logic             last_beat;
    logic             cnt_load;
    logic             cnt_en;
    logic [SEL_W-1:0] cnt_load_val;
    logic [SEL_W-1:0] sel;
    logic             sel_tc;

    always_comb begin
        accept       = (state_q == IDLE) && bus.in_valid;
        beat         = out_valid_q && bus.out_ready;
        last_beat    = beat && sel_tc;

        state_d      = state_q;
        data_d       = data_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    data_d      = bus.in_data;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            SHIFT: begin
                if (last_beat) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // The select parks at 0 between words, so the final beat reloads it as well.
        cnt_load     = accept || last_beat;
        cnt_load_val = accept ? SEL_START : '0;
        cnt_en       = beat && !sel_tc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    mux16_sel_counter #(
        .SEL_W (SEL_W)
    ) u_sel_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .down     (MSB_FIRST),
        .term     (SEL_FINAL),
        .cnt      (sel),
        .tc       (sel_tc)
    );

    assign bus.in_ready   = in_ready_q;
    assign bus.mux_datain = data_q;
    assign bus.mux_sel    = sel;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bit    = bus.mux_y;
    // In IDLE with MSB_FIRST the parked select equals the final index, hence the gate.
    assign bus.out_last   = out_valid_q && sel_tc;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux16_serial_sequencer.sv
// Directed bench for mux16_serial_sequencer: one LSB-first and one MSB-first
// instance, each feeding a behavioural 16:1 mux.
module tb_mux16_serial_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    mux16_serial_sequencer_if if0 ();
    mux16_serial_sequencer_if if1 ();

    // The mux being sequenced.
    assign if0.mux_y = if0.mux_datain[if0.mux_sel];
    assign if1.mux_y = if1.mux_datain[if1.mux_sel];

    mux16_serial_sequencer #(.MSB_FIRST(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    mux16_serial_sequencer #(.MSB_FIRST(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit which, input logic v, input logic [15:0] d);
        if (which) begin
            if1.in_valid = v;
            if1.in_data  = d;
        end else begin
            if0.in_valid = v;
            if0.in_data  = d;
        end
    endtask

    task automatic set_ready(input bit which, input logic r);
        if (which) if1.out_ready = r;
        else       if0.out_ready = r;
    endtask

    task automatic sample(input bit which, output logic rdy, output logic vld,
                          output logic bit_o, output logic last, output logic bsy,
                          output logic [3:0] sel, output logic [15:0] dat);
        if (which) begin
            rdy = if1.in_ready;  vld = if1.out_valid; bit_o = if1.out_bit;
            last = if1.out_last; bsy = if1.busy; sel = if1.mux_sel; dat = if1.mux_datain;
        end else begin
            rdy = if0.in_ready;  vld = if0.out_valid; bit_o = if0.out_bit;
            last = if0.out_last; bsy = if0.busy; sel = if0.mux_sel; dat = if0.mux_datain;
        end
    endtask

    task automatic check_idle(input bit which, input logic [15:0] exp_dat, input string tag);
        logic rdy, vld, bit_o, last, bsy;
        logic [3:0]  sel;
        logic [15:0] dat;
        sample(which, rdy, vld, bit_o, last, bsy, sel, dat);
        check_eq({tag, " in_ready"},   32'(rdy),  32'd1);
        check_eq({tag, " out_valid"},  32'(vld),  32'd0);
        check_eq({tag, " out_last"},   32'(last), 32'd0);
        check_eq({tag, " busy"},       32'(bsy),  32'd0);
        check_eq({tag, " mux_sel"},    32'(sel),  32'd0);
        check_eq({tag, " mux_datain"}, 32'(dat),  32'(exp_dat));
    endtask

    // Called in the first cycle after the accept edge; returns at the cycle after the last beat.
    task automatic expect_word(input bit which, input logic [15:0] word, input bit toggle,
                               input int pulse_cyc, input int abort_at, output int cycles);
        int beats = 0;
        int cyc   = 0;
        logic rdy, vld, bit_o, last, bsy, r;
        logic [3:0]  sel;
        logic [3:0]  es;
        logic [15:0] dat;
        while (beats < 16 && beats != abort_at && cyc < 100) begin
            r = toggle ? ((cyc % 2) == 1) : 1'b1;
            set_ready(which, r);
            if (pulse_cyc >= 0 && cyc == pulse_cyc)     drive(which, 1'b1, 16'hFFFF);
            if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) drive(which, 1'b0, 16'hFFFF);
            sample(which, rdy, vld, bit_o, last, bsy, sel, dat);
            es = which ? 4'(15 - beats) : 4'(beats);
            check_eq($sformatf("w%04h c%0d mux_sel", word, cyc), 32'(sel), 32'(es));
            check_eq($sformatf("w%04h c%0d out_bit", word, cyc), 32'(bit_o), 32'(word[es]));
            check_eq($sformatf("w%04h c%0d out_last", word, cyc), 32'(last), 32'(beats == 15));
            check_eq($sformatf("w%04h c%0d out_valid", word, cyc), 32'(vld), 32'd1);
            check_eq($sformatf("w%04h c%0d in_ready", word, cyc), 32'(rdy), 32'd0);
            check_eq($sformatf("w%04h c%0d busy", word, cyc), 32'(bsy), 32'd1);
            if (r) beats++;
            cyc++;
            @(negedge clk);
        end
        if (abort_at < 0) check_eq($sformatf("w%04h beat_count", word), 32'(beats), 32'd16);
        set_ready(which, 1'b1);
        cycles = cyc;
    endtask

    task automatic start_word(input bit which, input logic [15:0] word);
        logic rdy, vld, bit_o, last, bsy;
        logic [3:0]  sel;
        logic [15:0] dat;
        drive(which, 1'b1, word);
        sample(which, rdy, vld, bit_o, last, bsy, sel, dat);
        check_eq($sformatf("w%04h accept in_ready", word), 32'(rdy), 32'd1);
        @(negedge clk);
        drive(which, 1'b0, word);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t0;
        drive(1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000);
        set_ready(1'b0, 1'b1);
        set_ready(1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle(1'b0, 16'h0000, "reset0");
        check_idle(1'b1, 16'h0000, "reset1");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(1'b0, 16'h0000, "post_reset0");

        // 15 then 30 back-to-back, in_valid held high throughout
        t0 = cyc_cnt;
        drive(1'b0, 1'b1, 16'd15);
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd30);
        expect_word(1'b0, 16'd15, 1'b0, -1, -1, c);
        check_eq("w15 cycles", 32'(c), 32'd16);
        check_eq("b2b idle in_ready", 32'(if0.in_ready), 32'd1);
        check_eq("b2b idle out_valid", 32'(if0.out_valid), 32'd0);
        check_eq("b2b idle datain", 32'(if0.mux_datain), 32'd15);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd30);
        expect_word(1'b0, 16'd30, 1'b0, -1, -1, c);
        check_idle(1'b0, 16'd30, "after_w30");
        check_eq("b2b total cycles", 32'(cyc_cnt - t0), 32'd34);

        // MSB-first instance
        start_word(1'b1, 16'h8001);
        expect_word(1'b1, 16'h8001, 1'b0, -1, -1, c);
        check_idle(1'b1, 16'h8001, "after_w8001");

        // Backpressure every other cycle
        start_word(1'b0, 16'hA5A5);
        expect_word(1'b0, 16'hA5A5, 1'b1, -1, -1, c);
        check_eq("wA5A5 cycles", 32'(c), 32'd32);
        check_idle(1'b0, 16'hA5A5, "after_wA5A5");

        // in_valid pulse during SHIFT is ignored
        start_word(1'b0, 16'h0000);
        expect_word(1'b0, 16'h0000, 1'b0, 5, -1, c);
        check_idle(1'b0, 16'h0000, "after_w0000");

        // Reset mid-word, then a fresh word
        start_word(1'b0, 16'h00FF);
        expect_word(1'b0, 16'h00FF, 1'b0, -1, 8, c);
        check_eq("w00FF beats before abort", 32'(c), 32'd8);
        rst_n = 1'b0;
        #1;
        check_idle(1'b0, 16'h0000, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(1'b0, 16'h0000, "after_abort");
        start_word(1'b0, 16'h0F0F);
        expect_word(1'b0, 16'h0F0F, 1'b0, -1, -1, c);
        check_idle(1'b0, 16'h0F0F, "after_w0F0F");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
